// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier and its narrowing stage.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 13;
  localparam int unsigned MULT_CNT_W = 4;

  // Saturation bounds for the default operand width.
  localparam logic [MULT_WIDTH-1:0] MULT_MAXP = {1'b0, {(MULT_WIDTH-1){1'b1}}};
  localparam logic [MULT_WIDTH-1:0] MULT_MINN = {1'b1, {(MULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/sat_narrow.sv
// Narrows a sign + double-width magnitude into a saturated signed WIDTH-bit value.
module sat_narrow
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               i_sign,
  input  logic [2*WIDTH-1:0] i_mag,
  output logic [WIDTH-1:0]   o_p,
  output logic               o_ovf
);

  // Largest negative magnitude that still fits, 2^(WIDTH-1).
  localparam logic [2*WIDTH-1:0] NEG_LIM  = (2*WIDTH)'(1) << (WIDTH-1);
  localparam logic [2*WIDTH-1:0] POS_LIM  = NEG_LIM - (2*WIDTH)'(1);
  localparam logic [WIDTH-1:0]   MAXP     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MINN     = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp the magnitude to the representable signed range and apply the sign.
  always_comb begin
    o_p   = '0;
    o_ovf = 1'b0;
    if (i_mag == '0) begin
      o_p   = '0;
      o_ovf = 1'b0;
    end else if (!i_sign) begin
      if (i_mag > POS_LIM) begin
        o_p   = MAXP;
        o_ovf = 1'b1;
      end else begin
        o_p = i_mag[WIDTH-1:0];
      end
    end else begin
      if (i_mag > NEG_LIM) begin
        o_p   = MINN;
        o_ovf = 1'b1;
      end else begin
        // Exactly 2^(WIDTH-1) negates to MINN in WIDTH bits.
        o_p = -i_mag[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Radix-2 shift-and-add signed multiplier with saturated WIDTH-bit result.
module seq_signed_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             ovf
);

  mult_state_t          r_state;
  mult_state_t          w_state_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign;
  logic [WIDTH-1:0]     r_p;
  logic                 r_ovf;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sat_p;
  logic                 w_sat_ovf;

  // |MIN| wraps to 2^(WIDTH-1), which is still correct as an unsigned magnitude.
  assign w_abs_a    = a[WIDTH-1] ? -a : a;
  assign w_abs_b    = b[WIDTH-1] ? -b : b;
  assign w_acc_next = r_acc + (r_mag_b[0] ? r_mag_a : '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH-1));
  assign w_accept   = (r_state == IDLE) && in_valid;

  sat_narrow #(
    .WIDTH(WIDTH)
  ) u_sat (
    .i_sign (r_sign),
    .i_mag  (w_acc_next),
    .o_p    (w_sat_p),
    .o_ovf  (w_sat_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; in_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_p     <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
      r_mag_a <= {{WIDTH{1'b0}}, w_abs_a};
      r_mag_b <= w_abs_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_mag_a <= r_mag_a << 1;
      r_mag_b <= r_mag_b >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_p   <= w_sat_p;
        r_ovf <= w_sat_ovf;
      end
    end
  end

  assign p   = r_p;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed and randomized checks for seq_signed_multiplier (WIDTH=13).
module tb_seq_signed_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] a;
  logic [12:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] p;
  logic        ovf;

  int errors;
  int checks;

  seq_signed_multiplier #(
    .WIDTH(13),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full signed product clamped to 13 bits; returns {ovf, p}.
  function automatic logic [13:0] ref_mul(input logic [12:0] x, input logic [12:0] y);
    int xi, yi, pr;
    xi = int'($signed(x));
    yi = int'($signed(y));
    pr = xi * yi;
    if (pr > 4095)  return {1'b1, 13'h0FFF};
    if (pr < -4096) return {1'b1, 13'h1000};
    return {1'b0, 13'(pr)};
  endfunction

  function automatic logic [12:0] rand_op();
    logic [12:0] v;
    case ($urandom_range(0, 3))
      0: v = 13'($urandom_range(0, 8191));
      1: v = 13'($urandom_range(0, 127)) - 13'd64;
      2: begin
        case ($urandom_range(0, 6))
          0: v = 13'h0000;
          1: v = 13'h0001;
          2: v = 13'h1FFF;
          3: v = 13'h0FFF;
          4: v = 13'h1000;
          5: v = 13'h0040;
          default: v = 13'h1FC0;
        endcase
      end
      default: v = 13'($urandom_range(0, 400)) - 13'd200;
    endcase
    return v;
  endfunction

  // Issues one operation with out_ready high; reports latency, result and post-handshake status.
  task automatic run_op(input logic [12:0] ia, input logic [12:0] ib, output int lat,
                        output logic [12:0] rp, output logic rovf,
                        output logic ov_after, output logic rdy_after);
    int w;
    w         = 0;
    lat       = -1;
    rp        = '0;
    rovf      = 1'b0;
    ov_after  = 1'b1;
    rdy_after = 1'b0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) return;
    a         = ia;
    b         = ib;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~ia;
    b        = ib + 13'd1;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rp   = p;
    rovf = ovf;
    if (out_valid) begin
      @(posedge clk); #1;
    end
    ov_after  = out_valid;
    rdy_after = in_ready;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (p !== 13'h0000)     begin errors++; $display("FAIL rst_p got %h want 0000", p); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [12:0] rp; logic rovf, ova, rdy;
    run_op(13'd3, 13'h1FFB, lat, rp, rovf, ova, rdy);
    checks++; if (lat !== 13)       begin errors++; $display("FAIL basic_latency got %0d want 13", lat); end
    checks++; if (rp !== 13'h1FF1)  begin errors++; $display("FAIL basic_p got %h want 1ff1", rp); end
    checks++; if (rovf !== 1'b0)    begin errors++; $display("FAIL basic_ovf got %b want 0", rovf); end
    checks++; if (ova !== 1'b0)     begin errors++; $display("FAIL basic_out_valid_after got %b want 0", ova); end
    checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL basic_in_ready_after got %b want 1", rdy); end
  endtask

  task automatic test_saturation();
    logic [12:0] va [3] = '{13'd100, 13'h1000, 13'h1F9C};
    logic [12:0] vb [3] = '{13'd100, 13'h1FFF, 13'd100};
    logic [12:0] ep [3] = '{13'h0FFF, 13'h0FFF, 13'h1000};
    int lat; logic [12:0] rp; logic rovf, ova, rdy;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, rp, rovf, ova, rdy);
      checks++; if (lat !== 13)    begin errors++; $display("FAIL sat%0d_latency got %0d want 13", i, lat); end
      checks++; if (rp !== ep[i])  begin errors++; $display("FAIL sat%0d_p got %h want %h", i, rp, ep[i]); end
      checks++; if (rovf !== 1'b1) begin errors++; $display("FAIL sat%0d_ovf got %b want 1", i, rovf); end
    end
  endtask

  task automatic test_boundary();
    logic [12:0] va [4] = '{13'h1FC0, 13'd0,    13'h0FFF, 13'h1FFF};
    logic [12:0] vb [4] = '{13'h0040, 13'h1FF9, 13'd1,    13'h1FFF};
    logic [12:0] ep [4] = '{13'h1000, 13'h0000, 13'h0FFF, 13'h0001};
    int lat; logic [12:0] rp; logic rovf, ova, rdy;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, rp, rovf, ova, rdy);
      checks++; if (lat !== 13)    begin errors++; $display("FAIL bnd%0d_latency got %0d want 13", i, lat); end
      checks++; if (rp !== ep[i])  begin errors++; $display("FAIL bnd%0d_p got %h want %h", i, rp, ep[i]); end
      checks++; if (rovf !== 1'b0) begin errors++; $display("FAIL bnd%0d_ovf got %b want 0", i, rovf); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    int bad;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    a = 13'd7; b = 13'd9; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
    checks++; if (w !== 13) begin errors++; $display("FAIL bp_latency got %0d want 13", w); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; a = 13'd1; b = 13'd1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || p !== 13'd63 || ovf !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    checks++; if (p !== 13'd63)       begin errors++; $display("FAIL bp_p_retained got %h want 003f", p); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_no_extra_result got %0d valid cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int lat; int bad; logic [12:0] rp; logic rovf, ova, rdy;
    a = 13'd5; b = 13'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    checks++; if (p !== 13'h0000)     begin errors++; $display("FAIL rmid_p got %h want 0000", p); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL rmid_ovf got %b want 0", ovf); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_stale got %0d valid cycles want 0", bad); end
    run_op(13'd2, 13'd3, lat, rp, rovf, ova, rdy);
    checks++; if (lat !== 13)   begin errors++; $display("FAIL rmid_latency got %0d want 13", lat); end
    checks++; if (rp !== 13'd6) begin errors++; $display("FAIL rmid_p got %h want 0006", rp); end
    checks++; if (rovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf_after got %b want 0", rovf); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] q[$];
    logic [13:0] e;
    int issued, done, cyc, acc_cyc;
    logic prev_ov, acc_now;
    issued = 0; done = 0; cyc = 0; acc_cyc = 0;
    prev_ov = 1'b0; acc_now = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (done < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid && !prev_ov) begin
        checks++;
        if (cyc - acc_cyc != 13) begin
          errors++; $display("FAIL b2b_latency got %0d want 13", cyc - acc_cyc);
        end
      end
      prev_ov = out_valid;
      if (acc_now) in_valid = 1'b0;
      if (!in_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
        a = rand_op();
        b = rand_op();
        in_valid = 1'b1;
        issued++;
        q.push_back(ref_mul(a, b));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc_now = in_valid && in_ready;
      if (acc_now) acc_cyc = cyc + 1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result got p=%h want none", p);
        end else begin
          e = q.pop_front();
          if ({ovf, p} !== e) begin
            errors++; $display("FAIL b2b_result%0d got ovf=%b p=%h want ovf=%b p=%h", done, ovf, p, e[13], e[12:0]);
          end
        end
        done++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (done < 1000) begin
      checks++; errors++;
      $display("FAIL b2b_timeout got %0d results want 1000", done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_signed_multiplier.md
Name: seq_signed_multiplier

Overview:
- Sequential radix-2 shift-and-add signed multiplier; the doubling counterpart of the core's arithmetic halving.
- Computes p = a * b on signed (2's complement) WIDTH-bit operands.
- Result is saturated back to WIDTH bits.
- Sits in the line-drawing core datapath to form scaled error terms (e.g. 2*dy, dx*k), using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 13, operand and result width, signed 2's complement.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  signed multiplicand.
- b  input  WIDTH  signed multiplier.
- out_valid  output  1  result p/ovf valid.
- out_ready  input  1  consumer accepts result.
- p  output  WIDTH  signed saturated product.
- ovf  output  1  product was saturated.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0: state=IDLE, in_ready=0, out_valid=0, p=0, ovf=0, internal accumulator/counter=0. in_ready is driven from state, so it reads 1 from the first cycle after reset release.
- Reset mid-operation: aborts immediately. No result is produced for the in-flight operands.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, the block latches sign = a[W-1]^b[W-1] and mag_a = |a|, mag_b = |b| as unsigned WIDTH-bit values (|-4096| = 4096 fits).
  - The same edge clears acc (2*WIDTH bits) and cnt, and moves to RUN.
- RUN: in_ready=0. Each edge:
  - if mag_b[0], acc += mag_a_ext;
  - mag_a_ext <<= 1 (2*WIDTH bits);
  - mag_b >>= 1;
  - cnt++.
- RUN exit: on the edge where cnt==WIDTH-1, the block applies the final add, writes p/ovf, sets out_valid=1 and moves to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accept edge (13 for the default). Latency is fixed and independent of operand values; there is no early exit.
- Saturation, with MAXP = 2^(W-1)-1 and MINN = -2^(W-1):
  - sign=0 and mag>MAXP: p=MAXP, ovf=1.
  - sign=1 and mag>2^(W-1): p=MINN, ovf=1.
  - sign=1 and mag==2^(W-1): p=MINN, ovf=0.
  - mag==0: p=0, ovf=0, regardless of sign.
  - Otherwise p = sign ? -mag : mag, ovf=0.
- DONE: out_valid=1; p and ovf are held stable until an edge with out_ready=1. On that edge out_valid goes to 0, state goes to IDLE, and in_ready reads 1 in the next cycle.
  - in_ready=0 in DONE: no overlap, no bypass.
  - Minimum issue interval is WIDTH+2 cycles.
- in_valid during RUN/DONE is ignored. The producer must hold it until in_ready is seen.
- The a/b inputs are sampled only on the accept edge; later changes to them do not affect the in-flight result.
- p/ovf retain their last values after handshake completion until the next result is written.

Decomposition:
- Shared package mult_pkg holds:
  - WIDTH default;
  - MAXP/MINN constants derived from WIDTH;
  - state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- One combinational sub-module, sat_narrow: inputs sign and 2*WIDTH-bit magnitude; outputs WIDTH-bit p and ovf per the rules above. It is reused by other narrowing stages in the core.
- The FSM, counter and shift-add datapath stay in seq_signed_multiplier.

Test Plan:
- a=3, b=-5, out_ready=1 -> out_valid exactly 13 edges after accept; p=-15 (13'h1FF1), ovf=0; in_ready high again 2 cycles after accept of result.
- a=100, b=100 -> 10000 > 4095 -> p=4095 (13'h0FFF), ovf=1. Also a=-4096, b=-1 -> p=4095, ovf=1.
- a=-64, b=64 -> p=-4096 (13'h1000), ovf=0. Also a=0, b=-7 -> p=0, ovf=0.
- Back-pressure: a=7, b=9, out_ready=0 for 20 cycles -> out_valid stays 1, p=63 held; in_valid with a=1, b=1 during the stall is ignored (in_ready=0). Raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: drop rst_n 5 cycles into RUN -> out_valid=0, p=0, ovf=0 asynchronously, before the next edge. Release, issue a=2, b=3 -> p=6 after 13 edges, with no stale result emitted.
- Back-to-back randomized: 1000 operand pairs with random in_valid/out_ready -> each p/ovf matches a saturated reference model; results in order; every accept-to-out_valid latency equals 13.
